// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, framebuffer geometry and scanout types.
// Declarations only: no state, no latency, no flow control.
package vga_pkg;

  localparam int H_ACT   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;

  localparam int V_ACT   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam int FB_W    = 160;
  localparam int FB_H    = 120;

  localparam int CNT_W   = 10;
  localparam int ADDR_W  = 15;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef logic [2:0]        pix3_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } colour_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

  // Row stride of 160 built as 128+32 so no multiplier is inferred.
  function automatic fb_addr_t fb_addr(input cnt_t h, input cnt_t v, input int sh);
    fb_addr_t vy;
    fb_addr_t hx;
    vy = fb_addr_t'(v >> sh);
    hx = fb_addr_t'(h >> sh);
    return (vy << 7) + (vy << 5) + hx;
  endfunction

  function automatic colour_t expand_colour(input pix3_t d);
    colour_t c;
    c.r = {10{d[2]}};
    c.g = {10{d[1]}};
    c.b = {10{d[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel/line counters with raw (undelayed) HS/VS/active and a one-cycle frame_start.
// Counters step only on pix_en; free-running, no backpressure.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACT,
  parameter int V_ACTIVE = V_ACT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  pix_en,
  output cnt_t  h_cnt,
  output cnt_t  v_cnt,
  output sync_t sync_raw,
  output logic  frame_start
);

  // Porches and sync widths stay fixed; only the visible area scales.
  localparam int H_TOT = H_ACTIVE + (H_TOTAL - H_ACT);
  localparam int V_TOT = V_ACTIVE + (V_TOTAL - V_ACT);

  localparam cnt_t H_LAST     = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_TOT - 1);
  localparam cnt_t H_VIS      = cnt_t'(H_ACTIVE);
  localparam cnt_t V_VIS      = cnt_t'(V_ACTIVE);
  localparam cnt_t V_VIS_LAST = cnt_t'(V_ACTIVE - 1);
  localparam cnt_t HS_BEG     = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END     = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_BEG     = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END     = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt <= '0;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
          // Fires in the same cycle v_cnt steps from last visible line into blanking.
          if (v_cnt == V_VIS_LAST) begin
            frame_start <= 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sync_raw        = SYNC_IDLE;
    sync_raw.hs     = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
    sync_raw.vs     = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
    sync_raw.active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

endmodule

// File: rtl/vga_scanout.sv
// Scans a 160x120 3-bit framebuffer out to a VGA DAC, each buffer pixel replicated 4x4.
// Pins lag address issue by one pixel; free-running, no backpressure (memory answers in one cycle).
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACT,
  parameter int V_ACTIVE   = V_ACT,
  parameter int SCALE_LOG2 = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_data,
  output logic              frame_start,
  output logic [9:0]        VGA_R,
  output logic [9:0]        VGA_G,
  output logic [9:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic              VGA_CLK
);

  logic    phase;
  logic    pix_en;
  cnt_t    h_cnt;
  cnt_t    v_cnt;
  sync_t   sync_raw;
  sync_t   sync_iss;
  sync_t   sync_out;
  pix3_t   data_q;
  colour_t colour_q;

  // Phase clears to 0 so the very first edge after reset is a pixel edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  assign pix_en  = ~phase;
  assign VGA_CLK = phase;

  vga_sync_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_sync_gen (
    .clk         (CLOCK_50),
    .rst         (reset),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .sync_raw    (sync_raw),
    .frame_start (frame_start)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd_addr  <= '0;
      sync_iss <= SYNC_IDLE;
    end else if (pix_en) begin
      rd_addr  <= sync_raw.active ? fb_addr(h_cnt, v_cnt, SCALE_LOG2) : '0;
      sync_iss <= sync_raw;
    end
  end

  // Memory answers in the off-phase cycle between two pixel edges.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (!pix_en) begin
      data_q <= rd_data;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_out <= SYNC_IDLE;
      colour_q <= '0;
    end else if (pix_en) begin
      sync_out <= sync_iss;
      colour_q <= sync_iss.active ? expand_colour(data_q) : '0;
    end
  end

  assign VGA_HS      = sync_out.hs;
  assign VGA_VS      = sync_out.vs;
  assign VGA_BLANK_N = sync_out.active;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = colour_q.r;
  assign VGA_G       = colour_q.g;
  assign VGA_B       = colour_q.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout with a shrunken 64x8 visible area (real porches/sync widths).
// Expected event cycles and pixel probes are queued up front; a negedge monitor pops and compares.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int T_HA = 64;
  localparam int T_VA = 8;
  localparam int T_SC = 2;
  localparam int T_HT = T_HA + H_FP + H_SYNC + H_BP;   // 224 pixels per line
  localparam int T_VT = T_VA + V_FP + V_SYNC + V_BP;   // 53 lines per frame

  // Pixel p issues its address on edge 2p+1 after release; pins show it on edge 2p+3.
  localparam int LINE_CYC  = 2 * T_HT;                 // 448
  localparam int FRAME_CYC = 2 * T_HT * T_VT;          // 23744
  localparam int HS_FALL0  = 2 * (T_HA + H_FP) + 3;    // 163
  localparam int HS_RISE0  = 2 * (T_HA + H_FP + H_SYNC) + 3;          // 355
  localparam int VS_FALL0  = 2 * ((T_VA + V_FP) * T_HT) + 3;          // 8067
  localparam int VS_RISE0  = 2 * ((T_VA + V_FP + V_SYNC) * T_HT) + 3; // 8963
  localparam int FS0       = 2 * (T_VA * T_HT - 1) + 1;               // 3583
  localparam int RST_CYC   = 2 * (2 * T_HT * T_VT + 5 * T_HT + 100) + 1; // 49929: frame 2, v=5, in HS low
  localparam int PH2_END   = 4000;
  localparam int ADDR_LAST = 175;                      // (7>>2)*160 + (63>>2)

  typedef struct {
    int          cyc;
    bit          is_pix;
    int          h;
    int          v;
    int          addr;
    logic [29:0] rgb;
    logic        blank_n;
  } probe_t;

  logic        clk;
  logic        rst;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic        frame_start;
  logic [9:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

  int     cyc;
  int     n_checks;
  int     n_fail;
  int     blank_viol;
  int     max_addr;
  logic   mon_en;
  logic   prev_hs, prev_vs, prev_fs;
  int     q_hsf[$];
  int     q_hsr[$];
  int     q_vsf[$];
  int     q_vsr[$];
  int     q_fs[$];
  probe_t q_pr[$];
  probe_t pr;

  vga_scanout #(
    .H_ACTIVE   (T_HA),
    .V_ACTIVE   (T_VA),
    .SCALE_LOG2 (T_SC)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_start (frame_start),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK_N (vga_blank_n),
    .VGA_SYNC_N  (vga_sync_n),
    .VGA_CLK     (vga_clk)
  );

  // Framebuffer model: data = addr[2:0], except address 0 returns white so blanking is visible.
  assign rd_data = (rd_addr == 15'd0) ? 3'b111 : rd_addr[2:0];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d, required none", name, cyc);
  endtask

  task automatic plan_events(input int limit);
    for (int c = HS_FALL0; c <= limit; c += LINE_CYC)  q_hsf.push_back(c);
    for (int c = HS_RISE0; c <= limit; c += LINE_CYC)  q_hsr.push_back(c);
    for (int c = VS_FALL0; c <= limit; c += FRAME_CYC) q_vsf.push_back(c);
    for (int c = VS_RISE0; c <= limit; c += FRAME_CYC) q_vsr.push_back(c);
    for (int c = FS0;      c <= limit; c += FRAME_CYC) q_fs.push_back(c);
  endtask

  task automatic push_pix(input int h, input int v, input int f, input int exp_addr,
                          input logic [2:0] exp_c, input logic exp_act);
    probe_t p;
    int     pix;
    pix       = f * T_HT * T_VT + v * T_HT + h;
    p.h       = h;
    p.v       = v;
    p.addr    = exp_addr;
    p.rgb     = {{10{exp_c[2]}}, {10{exp_c[1]}}, {10{exp_c[0]}}};
    p.blank_n = exp_act;
    p.cyc     = 2 * pix + 1;
    p.is_pix  = 1'b0;
    q_pr.push_back(p);
    p.cyc     = 2 * pix + 3;
    p.is_pix  = 1'b1;
    q_pr.push_back(p);
  endtask

  task automatic end_phase(input string tag);
    check({tag, "_hs_fall_left"}, q_hsf.size(), 0);
    check({tag, "_hs_rise_left"}, q_hsr.size(), 0);
    check({tag, "_vs_fall_left"}, q_vsf.size(), 0);
    check({tag, "_vs_rise_left"}, q_vsr.size(), 0);
    check({tag, "_frame_start_left"}, q_fs.size(), 0);
    check({tag, "_probe_left"}, q_pr.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hs && !vga_hs) begin
        if (q_hsf.size() == 0) unexpected("hs_fall");
        else check("hs_fall_cycle", cyc, q_hsf.pop_front());
      end
      if (!prev_hs && vga_hs) begin
        if (q_hsr.size() == 0) unexpected("hs_rise");
        else check("hs_rise_cycle", cyc, q_hsr.pop_front());
      end
      if (prev_vs && !vga_vs) begin
        if (q_vsf.size() == 0) unexpected("vs_fall");
        else check("vs_fall_cycle", cyc, q_vsf.pop_front());
      end
      if (!prev_vs && vga_vs) begin
        if (q_vsr.size() == 0) unexpected("vs_rise");
        else check("vs_rise_cycle", cyc, q_vsr.pop_front());
      end
      if (frame_start) begin
        if (prev_fs) unexpected("frame_start_wide");
        else if (q_fs.size() == 0) unexpected("frame_start");
        else check("frame_start_cycle", cyc, q_fs.pop_front());
      end
      while (q_pr.size() > 0 && q_pr[0].cyc == cyc) begin
        pr = q_pr.pop_front();
        if (!pr.is_pix) begin
          check($sformatf("rd_addr(%0d,%0d)", pr.h, pr.v), rd_addr, pr.addr);
        end else begin
          check($sformatf("rgb(%0d,%0d)", pr.h, pr.v), {vga_r, vga_g, vga_b}, pr.rgb);
          check($sformatf("blank_n(%0d,%0d)", pr.h, pr.v), vga_blank_n, pr.blank_n);
        end
      end
      if (!vga_blank_n && ({vga_r, vga_g, vga_b} != 30'd0)) blank_viol++;
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    end
    prev_hs = vga_hs;
    prev_vs = vga_vs;
    prev_fs = frame_start;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    blank_viol = 0;
    max_addr   = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    repeat (4) @(negedge clk);

    // Phase 1: two frames from a clean release, then reset mid-frame.
    plan_events(RST_CYC);
    push_pix(0,   0, 0, 0,   3'b111, 1'b1);
    push_pix(4,   0, 0, 1,   3'b001, 1'b1);
    push_pix(64,  0, 0, 0,   3'b000, 1'b0);
    push_pix(100, 3, 0, 0,   3'b000, 1'b0);
    push_pix(8,   4, 0, 162, 3'b010, 1'b1);
    push_pix(63,  7, 0, 175, 3'b111, 1'b1);
    push_pix(10,  8, 0, 0,   3'b000, 1'b0);
    push_pix(20,  5, 1, 165, 3'b101, 1'b1);
    mon_en = 1'b1;
    rst    = 1'b0;
    while (cyc != RST_CYC) @(negedge clk);
    #1;
    mon_en = 1'b0;
    end_phase("ph1");

    check("pre_reset_hs", vga_hs, 0);
    check("pre_reset_vga_clk", vga_clk, 1);
    rst = 1'b1;
    #1;
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_blank_n", vga_blank_n, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_vga_clk", vga_clk, 0);
    check("sync_n", vga_sync_n, 0);
    repeat (3) @(negedge clk);

    // Phase 2: scan restarts at (0,0); frame_start only at its normal slot.
    plan_events(PH2_END);
    push_pix(0, 0, 0, 0,   3'b111, 1'b1);
    push_pix(4, 0, 0, 1,   3'b001, 1'b1);
    push_pix(8, 4, 0, 162, 3'b010, 1'b1);
    mon_en = 1'b1;
    rst    = 1'b0;
    while (cyc != PH2_END) @(negedge clk);
    #1;
    mon_en = 1'b0;
    end_phase("ph2");

    check("blank_colour_violations", blank_viol, 0);
    check("rd_addr_max", max_addr, ADDR_LAST);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
